// File: rtl/state_seq_pkg.sv
// Shared parameters for the major-state sequencer, PC and datapath blocks:
// major/minor state encodings, opcode constants and small IR decode helpers.
// Instruction register bits are numbered 0 (MSB) through 11 (LSB).
package state_seq_pkg;

    typedef enum logic [4:0] {
        ST_F0  = 5'd0,
        ST_FW  = 5'd1,
        ST_F1  = 5'd2,
        ST_F2  = 5'd3,
        ST_F2A = 5'd4,
        ST_F2B = 5'd5,
        ST_F3  = 5'd6,
        ST_D0  = 5'd8,
        ST_D1  = 5'd9,
        ST_D2  = 5'd10,
        ST_D3  = 5'd11,
        ST_E0  = 5'd12,
        ST_E1  = 5'd13,
        ST_E2  = 5'd14,
        ST_E3  = 5'd15,
        ST_H0  = 5'd16,
        ST_H1  = 5'd17,
        ST_H2  = 5'd18,
        ST_H3  = 5'd19,
        ST_HW  = 5'd20
    } state_t;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_TAD = 3'd1;
    localparam logic [2:0] OP_ISZ = 3'd2;
    localparam logic [2:0] OP_DCA = 3'd3;
    localparam logic [2:0] OP_JMS = 3'd4;
    localparam logic [2:0] OP_JMP = 3'd5;
    localparam logic [2:0] OP_IOT = 3'd6;
    localparam logic [2:0] OP_OPR = 3'd7;

    // Opcode plus indirect bit, for blocks that distinguish JMP forms.
    localparam logic [3:0] OP_JMPD = {OP_JMP, 1'b0};
    localparam logic [3:0] OP_JMPI = {OP_JMP, 1'b1};

    // OPR group 1 with a rotate-twice request needs two extra fetch cycles.
    function automatic logic is_double_rotate(input logic [0:11] ir);
        return (ir[0:2] == OP_OPR) && !ir[3] && ir[10] && (ir[8] || ir[9]);
    endfunction

    // OPR group 2 HLT microinstruction.
    function automatic logic is_hlt(input logic [0:11] ir);
        return (ir[0:3] == 4'b1111) && ir[10] && !ir[11];
    endfunction

endpackage

// File: rtl/state_seq_edge_det.sv
// Rising-edge detector for a level input that is already synchronous/debounced.
// Reset clears the history so a level held high through reset reads as an edge.
module edge_det (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic rise
);

    logic prev;

    // Remember last cycle's level of the input.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= 1'b0;
        end else begin
            prev <= in;
        end
    end

    assign rise = in & ~prev;

endmodule

// File: rtl/state_seq.sv
// Major/minor state sequencer: fetch, defer, execute, interrupt entry and halt.
// Optional build macro SINGLE_STEP_EN: when defined, sstep_sw high at an
// instruction boundary stops the machine in HW after every instruction.
module state_seq
    import state_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [0:11] instruction,
    input  logic        mem_busy,
    input  logic        int_req,
    input  logic        int_ena,
    input  logic        stop_sw,
    input  logic        cont_sw,
    input  logic        sstep_sw,
    output logic [4:0]  state,
    output logic        int_in_prog,
    output logic        halted
);

    state_t     cur_state;
    state_t     nxt_state;
    state_t     bnd_state;
    logic       bnd_int;
    logic       int_entry;
    logic       halt_pend;
    logic       halt_pend_nxt;
    logic       halt_at_bnd;
    logic       hlt_decode;
    logic       iip_nxt;
    logic       cont_rise;
    logic [2:0] opcode;
    logic       indirect;
    logic       unused_ir_bits;

    assign opcode         = instruction[0:2];
    assign indirect       = instruction[3];
    assign unused_ir_bits = ^instruction[4:7];
    assign hlt_decode     = (cur_state == ST_F3) && is_hlt(instruction);

`ifdef SINGLE_STEP_EN
    assign halt_at_bnd = halt_pend | stop_sw | hlt_decode | sstep_sw;
`else
    logic unused_sstep;
    assign unused_sstep = sstep_sw;
    assign halt_at_bnd  = halt_pend | stop_sw | hlt_decode;
`endif

    edge_det u_cont_edge (
        .clk   (clk),
        .reset (reset),
        .in    (cont_sw),
        .rise  (cont_rise)
    );

    // Next-state selection, including the shared instruction-boundary decision.
    always_comb begin
        nxt_state = ST_HW;
        int_entry = 1'b0;
        bnd_int   = 1'b0;
        bnd_state = ST_F0;

        if (halt_at_bnd) begin
            bnd_state = ST_H0;
        end else if (int_req && int_ena && !int_in_prog) begin
            bnd_state = ST_E0;
            bnd_int   = 1'b1;
        end

        case (cur_state)
            ST_F0:  nxt_state = mem_busy ? ST_FW : ST_F1;
            ST_FW:  nxt_state = mem_busy ? ST_FW : ST_F1;
            ST_F1:  nxt_state = ST_F2;
            ST_F2:  nxt_state = is_double_rotate(instruction) ? ST_F2A : ST_F3;
            ST_F2A: nxt_state = ST_F2B;
            ST_F2B: nxt_state = ST_F3;
            ST_F3: begin
                if ((opcode <= OP_JMP) && indirect) begin
                    nxt_state = ST_D0;
                end else if ((opcode <= OP_JMS) && !indirect) begin
                    nxt_state = ST_E0;
                end else begin
                    nxt_state = bnd_state;
                    int_entry = bnd_int;
                end
            end
            ST_D0:  nxt_state = ST_D1;
            ST_D1:  nxt_state = ST_D2;
            ST_D2:  nxt_state = ST_D3;
            ST_D3: begin
                if (opcode == OP_JMP) begin
                    nxt_state = bnd_state;
                    int_entry = bnd_int;
                end else begin
                    nxt_state = ST_E0;
                end
            end
            ST_E0:  nxt_state = ST_E1;
            ST_E1:  nxt_state = ST_E2;
            ST_E2:  nxt_state = ST_E3;
            ST_E3: begin
                nxt_state = bnd_state;
                int_entry = bnd_int;
            end
            ST_H0:  nxt_state = ST_H1;
            ST_H1:  nxt_state = ST_H2;
            ST_H2:  nxt_state = ST_H3;
            ST_H3:  nxt_state = ST_HW;
            ST_HW:  nxt_state = cont_rise ? ST_F0 : ST_HW;
            default: nxt_state = ST_HW;
        endcase
    end

    // Halt request latch and interrupt-in-progress flag updates.
    always_comb begin
        halt_pend_nxt = halt_pend | stop_sw | hlt_decode;
        if (nxt_state == ST_H0) begin
            halt_pend_nxt = 1'b0;
        end

        iip_nxt = int_in_prog;
        if (int_entry) begin
            iip_nxt = 1'b1;
        end else if (cur_state == ST_E3) begin
            iip_nxt = 1'b0;
        end
    end

    // State register; reset parks the machine in HW and abandons any instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state   <= ST_HW;
            int_in_prog <= 1'b0;
            halted      <= 1'b1;
            halt_pend   <= 1'b0;
        end else begin
            cur_state   <= nxt_state;
            int_in_prog <= iip_nxt;
            halted      <= (nxt_state == ST_HW);
            halt_pend   <= halt_pend_nxt;
        end
    end

    assign state = cur_state;

endmodule

// File: doc/state_seq.md
STATE_SEQ -- requirements
Module: state_seq

Interface
REQ-001 SHALL have ports: clk  input  1  system clock, rising edge.
REQ-002 SHALL have: reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have: instruction  input  [0:11]  current IR contents, valid from F2 onward.
REQ-004 SHALL have: mem_busy  input  1  memory not ready for instruction fetch.
REQ-005 SHALL have: int_req  input  1  OR of device interrupt requests.
REQ-006 SHALL have: int_ena  input  1  interrupt enable flip-flop state.
REQ-007 SHALL have: stop_sw  input  1  front-panel STOP switch, level.
REQ-008 SHALL have: cont_sw  input  1  front-panel CONT switch, level, debounced externally.
REQ-009 SHALL have: sstep_sw  input  1  single-instruction switch, level.
REQ-010 SHALL have: state  output  [4:0]  major/minor state driven to PC, MA, AC datapath.
REQ-011 SHALL have: int_in_prog  output  1  high during the interrupt JMS sequence.
REQ-012 SHALL have: halted  output  1  high while in HW.

Function
REQ-013 State encoding SHALL be: F0=0, FW=1, F1=2, F2=3, F2A=4, F2B=5, F3=6, D0=8, D1=9, D2=10, D3=11, E0=12, E1=13, E2=14, E3=15, H0=16, H1=17, H2=18, H3=19, HW=20.
REQ-014 F0 SHALL go to FW if mem_busy=1, else to F1; FW SHALL hold while mem_busy=1, then go to F1.
REQ-015 F1 -> F2 unconditionally; F2 -> F2A if the instruction is OPR group 1 (bits 0:2=7, bit 3=0) with bit 10=1 and bit 8 or 9 set (double rotate), else -> F3; F2A -> F2B -> F3.
REQ-016 From F3: opcode 0-5 with bit 3=1 -> D0; opcode 0-4 with bit 3=0 -> E0; JMP direct, IOT (6) and OPR (7) -> instruction boundary.
REQ-017 D0->D1->D2->D3 unconditionally; D3 -> boundary for JMP (5), else -> E0.
REQ-018 E0->E1->E2->E3 unconditionally; E3 -> boundary.
REQ-019 Boundary decision, applied in the same cycle as the last state: halt pending -> H0; else if int_req=1 and int_ena=1 -> E0 with int_in_prog set; else -> F0.
REQ-020 Halt pending SHALL be set by: stop_sw=1 at any cycle; HLT (bits 0:3=4'b1111, bit 10=1, bit 11=0) decoded in F3. It SHALL be cleared on entry to H0.
REQ-021 H0->H1->H2->H3->HW unconditionally; HW holds until a rising edge of cont_sw, then -> F0.
REQ-022 int_in_prog SHALL rise on the clock entering interrupt E0, remain high through E3, and fall on the clock leaving E3.
REQ-023 An interrupt sequence SHALL never be followed directly by a second interrupt sequence; the boundary after an interrupt E3 SHALL go to F0 or H0 only.
REQ-024 stop_sw asserted mid-instruction SHALL NOT abort the instruction; the halt SHALL take effect at the next boundary.
REQ-025 A cont_sw edge outside HW SHALL be ignored.
REQ-026 halted SHALL equal (state==HW), registered with state.

Reset
REQ-027 reset SHALL force state=HW, int_in_prog=0, halted=1, halt pending=0, and clear the cont edge-detector history; reset SHALL override every other input in the same cycle.
REQ-028 reset asserted mid-instruction SHALL abandon the instruction with no further state progression.

Configuration
REQ-029 Macro SINGLE_STEP_EN: when defined, sstep_sw=1 at a boundary SHALL set halt pending, so the machine stops in HW after each instruction, including after an interrupt sequence; when undefined, sstep_sw SHALL be ignored and the port retained.

Structure
REQ-030 The state encodings (REQ-013) and opcode constants (AND..OPR, JMPD, JMPI, JMS, ISZ) SHALL live in the shared parameters include used by the PC and datapath blocks.
REQ-031 The cont_sw rising-edge detector SHALL be a sub-module named edge_det (clk, reset, in, rise).

Verification
REQ-032 reset, then cont_sw 0->1, mem_busy=0, instruction=7000 (NOP) -> states HW, F0, F1, F2, F3, F0.
REQ-033 instruction=1400 (TAD I 0) with mem_busy=1 for 3 cycles -> F0, FW x3, F1, F2, F3, D0-D3, E0-E3, F0.
REQ-034 instruction=5600 (JMP I) -> F3, D0-D3, then F0 with no E states.
REQ-035 int_req=1, int_ena=1 during instruction 7000 -> after F3: E0-E3 with int_in_prog=1, then F0 with int_in_prog=0 even though int_req is still 1.
REQ-036 instruction=7402 (HLT) -> F3, H0-H3, HW with halted=1; cont_sw pulse -> F0.
REQ-037 With SINGLE_STEP_EN defined and sstep_sw=1, instruction=7010 (RAR) -> F2 only, then F3, H0-H3, HW; instruction=7012 (RTR) -> F2, F2A, F2B, F3, H0.
